// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS main controller.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_BRANCHNE, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL
  } state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] AC_ADD   = 3'b010;
  localparam logic [2:0] AC_SUB   = 3'b110;
  localparam logic [2:0] AC_AND   = 3'b000;
  localparam logic [2:0] AC_OR    = 3'b001;
  localparam logic [2:0] AC_SLT   = 3'b111;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps alu_op/funct to alu_control; funct_legal is valid regardless of alu_op.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_control,
  output logic        funct_legal
);
  logic [2:0] fn_ctl;
  always_comb begin
    fn_ctl = AC_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  fn_ctl = AC_ADD;
      FN_SUB:  fn_ctl = AC_SUB;
      FN_AND:  fn_ctl = AC_AND;
      FN_OR:   fn_ctl = AC_OR;
      FN_SLT:  fn_ctl = AC_SLT;
      default: funct_legal = 1'b0;
    endcase
    alu_control = alu_op == ALU_SUB ? AC_SUB : alu_op == ALU_FUNCT ? fn_ctl : AC_ADD;
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS main controller with memory handshake, illegal trap and retire counter.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EN_ADDI       = 1'b1,
  parameter bit EN_JUMP       = 1'b1,
  parameter bit EN_BNE        = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic             mem_to_reg,
  output logic             reg_dest,
  output logic             alu_src_a,
  output logic             branch,
  output logic             branch_ne,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  state_t state, next;
  alu_op_t alu_op;
  logic funct_legal, mem_done, retire;
  logic mem_req_s, mem_write_s, ir_write_s, reg_write_s, pc_write_s, branch_s, branch_ne_s;
  alu_op_decoder u_dec (.alu_op(alu_op), .funct(funct), .alu_control(alu_control), .funct_legal(funct_legal));
  assign mem_done = !MEM_HANDSHAKE || mem_ready;
  // Every terminal state heads back to FETCH; nothing else does, so this marks retirement.
  assign retire = state != S_FETCH && next == S_FETCH;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  always_comb begin
    next = state;
    case (state)
      S_FETCH:   next = mem_done ? S_DECODE : S_FETCH;
      S_DECODE:  next = (opcode == OP_LW || opcode == OP_SW)    ? S_MEMADR   :
                        (opcode == OP_RTYPE && funct_legal)     ? S_EXECUTE  :
                        opcode == OP_BEQ                        ? S_BRANCH   :
                        (EN_BNE && opcode == OP_BNE)            ? S_BRANCHNE :
                        (EN_ADDI && opcode == OP_ADDI)          ? S_ADDIEX   :
                        (EN_JUMP && opcode == OP_J)             ? S_JUMP     : S_ILLEGAL;
      S_MEMADR:  next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next = mem_done ? S_MEMWB : S_MEMRD;
      S_MEMWR:   next = mem_done ? S_FETCH : S_MEMWR;
      S_EXECUTE: next = S_ALUWB;
      S_ADDIEX:  next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_BRANCHNE, S_ADDIWB, S_JUMP: next = S_FETCH;
      default:   next = state;
    endcase
  end
  always_comb begin
    mem_req_s = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s = 1'b0;
    reg_write_s = 1'b0;
    pc_write_s = 1'b0;
    branch_s = 1'b0;
    branch_ne_s = 1'b0;
    i_or_d = 1'b0;
    mem_to_reg = 1'b0;
    reg_dest = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    pc_src = PC_ALU;
    alu_op = ALU_ADD;
    case (state)
      S_FETCH:    begin mem_req_s = 1'b1; alu_src_b = SRCB_FOUR; ir_write_s = mem_done; pc_write_s = mem_done; end
      S_DECODE:   alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
      S_MEMRD:    begin mem_req_s = 1'b1; i_or_d = 1'b1; end
      S_MEMWB:    begin reg_write_s = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:    begin mem_req_s = 1'b1; i_or_d = 1'b1; mem_write_s = 1'b1; end
      S_EXECUTE:  begin alu_src_a = 1'b1; alu_op = ALU_FUNCT; end
      S_ALUWB:    begin reg_write_s = 1'b1; reg_dest = 1'b1; end
      S_BRANCH:   begin alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = PC_ALUOUT; branch_s = 1'b1; end
      S_BRANCHNE: begin alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = PC_ALUOUT; branch_ne_s = 1'b1; end
      S_ADDIWB:   reg_write_s = 1'b1;
      S_JUMP:     begin pc_src = PC_JUMP; pc_write_s = 1'b1; end
      default:    ;
    endcase
  end
  // Reset forces FETCH, so selects already match; only the strobes need masking.
  assign mem_req   = reset & mem_req_s;
  assign mem_write = reset & mem_write_s;
  assign ir_write  = reset & ir_write_s;
  assign reg_write = reset & reg_write_s;
  assign pc_write  = reset & pc_write_s;
  assign branch    = reset & branch_s;
  assign branch_ne = reset & branch_ne_s;
  assign illegal   = state == S_ILLEGAL;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction stream checked against a per-instruction latency/strobe model.
module tb_multicycle_control_fsm;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;
  logic clk = 1'b0, reset = 1'b0, reset_b = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0, opcode_b = '0, funct_b = '0;
  logic mem_req, i_or_d, mem_write, ir_write, reg_write, pc_write, mem_to_reg, reg_dest, alu_src_a, branch, branch_ne, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [31:0] retired;
  logic b_mem_req, b_i_or_d, b_mem_write, b_ir_write, b_reg_write, b_pc_write, b_mem_to_reg, b_reg_dest, b_alu_src_a, b_branch, b_branch_ne, b_illegal;
  logic [1:0] b_alu_src_b, b_pc_src, retired_b;
  logic [2:0] b_alu_control;
  int n_cmp = 0, n_err = 0;
  int o_cyc, o_ir, o_pc, o_rw, o_mtr, o_rd, o_mw, o_br, o_bn;
  logic o_done;
  logic [2:0] o_alu;
  logic [1:0] o_pcsrc;
  logic [31:0] exp_ret = 0;
  always #5 clk = ~clk;
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .pc_write(pc_write), .mem_to_reg(mem_to_reg), .reg_dest(reg_dest),
    .alu_src_a(alu_src_a), .branch(branch), .branch_ne(branch_ne), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_control(alu_control), .illegal(illegal), .retired(retired));
  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0), .EN_BNE(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset_b), .opcode(opcode_b), .funct(funct_b), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .i_or_d(b_i_or_d), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_write(b_reg_write), .pc_write(b_pc_write), .mem_to_reg(b_mem_to_reg), .reg_dest(b_reg_dest),
    .alu_src_a(b_alu_src_a), .branch(b_branch), .branch_ne(b_branch_ne), .alu_src_b(b_alu_src_b),
    .pc_src(b_pc_src), .alu_control(b_alu_control), .illegal(b_illegal), .retired(retired_b));
  function automatic int exp_lat(input logic [5:0] op);
    return op == LW ? 5 : (op == SW || op == RT || op == ADDI) ? 4 : 3;
  endfunction
  function automatic logic [2:0] exp_ctl(input logic [5:0] fn);
    return fn == 6'b100000 ? 3'b010 : fn == 6'b100010 ? 3'b110 : fn == 6'b100100 ? 3'b000 :
           fn == 6'b100101 ? 3'b001 : 3'b111;
  endfunction
  // Runs one instruction from FETCH: w1 not-ready cycles in fetch, w2 in the data access; elsewhere mem_ready is noise.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int w1, input int w2, input bit mem_op);
    logic [31:0] r0;
    opcode = op; funct = fn; r0 = retired;
    {o_cyc, o_ir, o_pc, o_rw, o_mtr, o_rd, o_mw, o_br, o_bn} = '0;
    o_done = 1'b0; o_alu = 'x; o_pcsrc = 'x;
    while (!o_done && o_cyc < 64) begin
      if (o_cyc < w1) mem_ready = 1'b0;
      else if (o_cyc == w1) mem_ready = 1'b1;
      else if (mem_op && o_cyc >= w1 + 3 && o_cyc < w1 + 3 + w2) mem_ready = 1'b0;
      else if (mem_op && o_cyc == w1 + 3 + w2) mem_ready = 1'b1;
      else mem_ready = 1'($urandom);
      #1;
      if (ir_write) o_ir++;
      if (pc_write) o_pc++;
      if (reg_write) o_rw++;
      if (reg_write && mem_to_reg) o_mtr++;
      if (reg_write && reg_dest) o_rd++;
      if (mem_write) o_mw++;
      if (branch) o_br++;
      if (branch_ne) o_bn++;
      if (o_cyc == w1 + 2) begin o_alu = alu_control; o_pcsrc = pc_src; end
      @(negedge clk);
      o_cyc++;
      if (retired != r0) o_done = 1'b1;
    end
  endtask
  task automatic test_reset;
    reset = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({mem_req, ir_write, pc_write, reg_write, mem_write, branch, branch_ne} !== 7'b0) begin n_err++; $display("FAIL reset_strobes got %b want 0", {mem_req, ir_write, pc_write, reg_write, mem_write, branch, branch_ne}); end
    n_cmp++; if ({alu_src_b, alu_control, i_or_d, alu_src_a, pc_src} !== {2'b01, 3'b010, 1'b0, 1'b0, 2'b00}) begin n_err++; $display("FAIL reset_selects got %b/%b want 01/010", alu_src_b, alu_control); end
    n_cmp++; if (retired !== 0 || illegal !== 1'b0) begin n_err++; $display("FAIL reset_state got ret=%0d ill=%b want 0/0", retired, illegal); end
    @(negedge clk);
    reset = 1'b1; opcode = LW; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b1 || i_or_d !== 1'b1) begin n_err++; $display("FAIL memrd_reached got req=%b iord=%b want 1/1", mem_req, i_or_d); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({mem_req, ir_write, pc_write, reg_write, mem_write, i_or_d} !== 6'b0) begin n_err++; $display("FAIL midreset_strobes got %b want 0", {mem_req, ir_write, pc_write, reg_write, mem_write, i_or_d}); end
    @(negedge clk);
    mem_ready = 1'b1; reset = 1'b1;
    #1;
    n_cmp++; if ({mem_req, ir_write, pc_write} !== 3'b111 || retired !== 0) begin n_err++; $display("FAIL restart_fetch got %b ret=%0d want 111 ret=0", {mem_req, ir_write, pc_write}, retired); end
  endtask
  task automatic test_lw;
    run_instr(LW, 6'd0, 3, 2, 1'b1);
    exp_ret++;
    n_cmp++; if (!o_done || o_cyc != 10) begin n_err++; $display("FAIL lw_latency got %0d done=%b want 10", o_cyc, o_done); end
    n_cmp++; if (o_mtr != 1 || o_rw != 1) begin n_err++; $display("FAIL lw_writeback got mtr=%0d rw=%0d want 1/1", o_mtr, o_rw); end
    n_cmp++; if (retired !== 1) begin n_err++; $display("FAIL lw_retired got %0d want 1", retired); end
  endtask
  task automatic test_slt_beq;
    int c1;
    logic [2:0] a1;
    int rd1;
    run_instr(RT, 6'b101010, 0, 0, 1'b0);
    c1 = o_cyc; a1 = o_alu; rd1 = o_rd;
    run_instr(BEQ, 6'd0, 0, 0, 1'b0);
    exp_ret += 2;
    n_cmp++; if (a1 !== 3'b111) begin n_err++; $display("FAIL slt_alu got %b want 111", a1); end
    n_cmp++; if (o_alu !== 3'b110 || o_pcsrc !== 2'b01 || o_br != 1) begin n_err++; $display("FAIL beq_ctl got alu=%b pcsrc=%b br=%0d want 110/01/1", o_alu, o_pcsrc, o_br); end
    n_cmp++; if (rd1 != 1) begin n_err++; $display("FAIL aluwb_regdest got %0d want 1", rd1); end
    n_cmp++; if (c1 + o_cyc != 7 || retired !== exp_ret) begin n_err++; $display("FAIL slt_beq_total got %0d cyc ret=%0d want 7 ret=%0d", c1 + o_cyc, retired, exp_ret); end
  endtask
  task automatic test_bne;
    run_instr(BNE, 6'd0, 1, 0, 1'b0);
    exp_ret++;
    n_cmp++; if (o_bn != 1 || o_br != 0 || o_pcsrc !== 2'b01) begin n_err++; $display("FAIL bne_ctl got bn=%0d br=%0d pcsrc=%b want 1/0/01", o_bn, o_br, o_pcsrc); end
    reset_b = 1'b1; opcode_b = BNE;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (b_illegal !== 1'b1 || b_mem_req !== 1'b0 || retired_b !== 2'd0) begin n_err++; $display("FAIL bne_disabled got ill=%b req=%b ret=%0d want 1/0/0", b_illegal, b_mem_req, retired_b); end
      @(negedge clk);
    end
    reset_b = 1'b0;
    #1;
    n_cmp++; if (b_illegal !== 1'b0) begin n_err++; $display("FAIL bne_reset_clear got %b want 0", b_illegal); end
  endtask
  task automatic test_random;
    logic [5:0] ops [7] = '{LW, SW, RT, BEQ, BNE, ADDI, JMP};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      int w1, w2, lat;
      bit mem;
      op = ops[$urandom_range(0, 6)];
      fn = op == RT ? fns[$urandom_range(0, 4)] : 6'($urandom);
      w1 = $urandom_range(0, 3); w2 = $urandom_range(0, 3);
      mem = op == LW || op == SW;
      lat = exp_lat(op) + w1 + (mem ? w2 : 0);
      run_instr(op, fn, w1, w2, mem);
      exp_ret++;
      n_cmp++; if (!o_done || o_cyc != lat) begin n_err++; $display("FAIL rand_latency op=%b got %0d want %0d", op, o_cyc, lat); end
      n_cmp++; if (retired !== exp_ret) begin n_err++; $display("FAIL rand_retired got %0d want %0d", retired, exp_ret); end
      n_cmp++; if (o_ir != 1 || o_pc != (op == JMP ? 2 : 1)) begin n_err++; $display("FAIL rand_fetch op=%b got ir=%0d pc=%0d", op, o_ir, o_pc); end
      n_cmp++; if (o_rw != int'(op == LW || op == RT || op == ADDI) || o_mtr != int'(op == LW) || o_rd != int'(op == RT)) begin n_err++; $display("FAIL rand_regwrite op=%b got rw=%0d mtr=%0d rd=%0d", op, o_rw, o_mtr, o_rd); end
      n_cmp++; if (o_mw != (op == SW ? w2 + 1 : 0)) begin n_err++; $display("FAIL rand_memwrite op=%b got %0d want %0d", op, o_mw, op == SW ? w2 + 1 : 0); end
      n_cmp++; if (o_br != int'(op == BEQ) || o_bn != int'(op == BNE)) begin n_err++; $display("FAIL rand_branch op=%b got br=%0d bn=%0d", op, o_br, o_bn); end
      if (op == RT) begin
        n_cmp++; if (o_alu !== exp_ctl(fn)) begin n_err++; $display("FAIL rand_funct fn=%b got %b want %b", fn, o_alu, exp_ctl(fn)); end
      end
    end
  endtask
  task automatic test_illegal_funct;
    opcode = RT; funct = 6'b000111; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      #1;
      n_cmp++; if (illegal !== 1'b1 || mem_req !== 1'b0 || {reg_write, pc_write, ir_write, mem_write} !== 4'b0 || retired !== exp_ret) begin n_err++; $display("FAIL illegal_hold got ill=%b req=%b ret=%0d want 1/0/%0d", illegal, mem_req, retired, exp_ret); end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (illegal !== 1'b0 || retired !== 0) begin n_err++; $display("FAIL illegal_reset got ill=%b ret=%0d want 0/0", illegal, retired); end
    @(negedge clk);
    reset = 1'b1; exp_ret = 0;
  endtask
  task automatic test_wrap;
    @(negedge clk);
    reset_b = 1'b1; opcode_b = JMP;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (b_pc_src !== 2'b10 || b_pc_write !== 1'b1) begin n_err++; $display("FAIL jump_ctl got pcsrc=%b pcw=%b want 10/1", b_pc_src, b_pc_write); end
    repeat (7) @(negedge clk);
    #1;
    n_cmp++; if (retired_b !== 2'd3) begin n_err++; $display("FAIL wrap_three got %0d want 3", retired_b); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (retired_b !== 2'd0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", retired_b); end
  endtask
  initial begin
    test_reset;
    test_lw;
    test_slt_beq;
    test_bne;
    test_random;
    test_illegal_funct;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised main controller for the multicycle MIPS core: one registered state machine plus ALU-operation decode, driving every datapath strobe and mux select. It extends the base instruction set (lw, sw, R-type, beq) with optional addi, j and bne, and adds a variable-latency memory handshake. It also provides a sticky illegal-instruction trap and a retired-instruction counter. Sits between the instruction register (opcode/funct) and the datapath/memory interface.

## Interface
- `MEM_HANDSHAKE`, 1: 1 = memory states wait for `mem_ready`; 0 = memory completes in one cycle, `mem_ready` ignored.
- `EN_ADDI`, 1: decode addi (opcode 001000).
- `EN_JUMP`, 1: decode j (000010).
- `EN_BNE`, 1: decode bne (000101).
- `CNT_W`, 32: retired-counter width (≥1).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `mem_ready` in 1: memory completion for current request.
- `mem_req` out 1: memory access active.
- `i_or_d` out 1: 0 = PC address, 1 = ALUOut address.
- `mem_write`, `ir_write`, `reg_write`, `pc_write` out 1 each: strobes.
- `mem_to_reg`, `reg_dest`, `alu_src_a` out 1 each: mux selects.
- `branch`, `branch_ne` out 1 each: PC enable = pc_write | branch&zero | branch_ne&~zero.
- `alu_src_b` out 2: 00 B, 01 const 4, 10 sign-imm, 11 sign-imm<<2.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_control` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: sticky trap flag.
- `retired` out CNT_W: completed-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, BRANCHNE, ADDIEX, ADDIWB, JUMP, ILLEGAL.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op add, pc_src=00. With handshake, ir_write and pc_write assert only in the cycle mem_ready=1, and the FSM stays in FETCH until then.
- DECODE: alu_src_a=0, alu_src_b=11, add. Next state:
  - lw/sw → MEMADR
  - R-type with legal funct → EXECUTE
  - beq → BRANCH
  - bne → BRANCHNE if EN_BNE
  - addi → ADDIEX if EN_ADDI
  - j → JUMP if EN_JUMP
  - anything else (including R-type with unknown funct, or a disabled opcode) → ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req=1, i_or_d=1. Advances to MEMWB when complete (mem_ready, or immediately if MEM_HANDSHAKE=0).
- MEMWB: reg_write=1, mem_to_reg=1, reg_dest=0.
- MEMWR: mem_req=1, i_or_d=1, mem_write=1. Held until complete.
- EXECUTE: alu_src_a=1, alu_src_b=00, funct decode.
- ALUWB: reg_write=1, reg_dest=1, mem_to_reg=0.
- BRANCH / BRANCHNE: alu_src_a=1, alu_src_b=00, sub, pc_src=01. branch=1 or branch_ne=1 respectively.
- ADDIEX: as MEMADR. ADDIWB: reg_write=1, reg_dest=0, mem_to_reg=0.
- JUMP: pc_src=10, pc_write=1.
- Terminal states (MEMWB, completed MEMWR, ALUWB, BRANCH, BRANCHNE, ADDIWB, JUMP) return to FETCH and increment `retired`, which wraps modulo 2^CNT_W.
- ILLEGAL: absorbing until reset. illegal=1, all strobes and mem_req 0, `retired` frozen.
- Funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Unlisted selects are 0.

## Timing
- Zero-wait latency in cycles: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3. Each wait cycle adds one.
- Outputs are combinational from state; only the FETCH/MEMRD/MEMWR strobes and transitions depend on mem_ready.
- mem_ready is sampled only while mem_req=1; it is ignored elsewhere.
- While reset is low:
  - state = FETCH, retired = 0, illegal = 0.
  - all strobes, mem_req, branch and branch_ne are forced 0.
  - selects take their FETCH values.
- Reset released mid-instruction: restart at FETCH; no partial strobe is issued.

## Structure
- Package `mips_ctrl_pkg`: state enum, opcode and funct constants, alu_op enum (add/sub/funct), alu_control codes, alu_src_b and pc_src encodings.
- Sub-module `alu_op_decoder`: combinational; inputs alu_op and funct, outputs alu_control and a funct_legal flag used by DECODE.

## Test plan
- Reset low mid-MEMRD, then high: all strobes 0 during reset; FETCH with pc_write=1 on the first cycle; retired=0.
- lw (100011), MEM_HANDSHAKE=1, mem_ready low 3 cycles in FETCH and 2 in MEMRD: lw completes in 10 cycles; reg_write=1 with mem_to_reg=1 exactly once; retired=1.
- R-type slt (000000/101010), then beq: alu_control 111 in EXECUTE and 110 in BRANCH; ALUWB gives reg_dest=1; retired=2 after 7 cycles.
- bne with EN_BNE=1: branch_ne=1, pc_src=01 in BRANCHNE. With EN_BNE=0, DECODE → ILLEGAL and illegal=1 until reset.
- R-type funct 000111 → ILLEGAL: illegal held 1 for 20 cycles, no mem_req, retired unchanged.
- CNT_W=2: four jumps (000010) take retired from 3 to 0, showing wrap.
